uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised successor to the fixed 8N1 115200-baud UART receiver. It generates its own bit timing from the system clock and supports configurable data width, parity and stop bits. It majority-samples each bit, flags framing and parity errors per word, and buffers received words in a first-word-fall-through FIFO with hardware flow control (cts). It sits between the external rx pin and the LED command parser.

Parameters:
CLOCK_HZ, 12000000, system clock frequency
BAUD, 115200, line rate; BIT_CYCLES = round(CLOCK_HZ/BAUD) (104 at defaults), HALF = BIT_CYCLES/2 (52)
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, power of two, >= 4
CTS_MARGIN, 2, free entries below which cts drops

Ports:
clock_12mhz  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
rx  in  1  serial line, idle high, asynchronous to clock
rx_data  out  DATA_BITS  head-of-FIFO word
rx_frame_error  out  1  head word had a low stop bit
rx_parity_error  out  1  head word parity mismatch; always 0 when PARITY=0
rx_data_valid  out  1  FIFO not empty
rx_data_ready  in  1  consumer pop; pop occurs when valid && ready
rx_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
cts  out  1  clear-to-send to the remote side
overrun  out  1  sticky: a word was dropped because the FIFO was full
error_clear  in  1  clears overrun

Behaviour:
- Reset (asynchronous): state IDLE, counters 0, FIFO empty, rx synchroniser flops = 1, rx_data = 0, rx_data_valid = 0, error flags = 0, overrun = 0, rx_level = 0, cts = 1.
- rx passes through a 2-flop synchroniser; all timing below is on the synchronised signal (rxs).
- Bit sample = majority of rxs at counter values HALF-1, HALF, HALF+1 within each bit period.
- FSM:
  - IDLE: on a falling edge of rxs, clear the counter and go to START.
  - START: sample at mid-bit. If high (glitch), return to IDLE and push nothing. Else go to DATA.
  - DATA: shift in DATA_BITS samples LSB first, one every BIT_CYCLES. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: parity_error = (XOR of data ^ sampled bit) != (PARITY==1 ? 1 : 0).
  - STOP: sample STOP_BITS stop bits. A low stop bit sets frame_error. Push {frame_error, parity_error, data} at the mid-sample of the last stop bit.
  - After the push: go to IDLE if rxs is high; otherwise go to BREAK_WAIT.
  - BREAK_WAIT: stay until rxs is high, then go to IDLE. A long break yields exactly one word, data 0 with frame_error = 1.
- FIFO is first-word-fall-through. A push is visible on rx_data / rx_data_valid on the cycle after the push edge. rx_data holds its value while empty.
- Pop and push on the same cycle:
  - Not full: both happen; level unchanged.
  - Full: the pop frees a slot and the push is accepted; no overrun.
- Push while full with no pop: the word is discarded, FIFO contents are unchanged, and overrun is set.
- overrun is cleared by error_clear. If overrun set and error_clear occur on the same cycle, set wins.
- Pop while empty is ignored.
- Pointers wrap modulo FIFO_DEPTH. rx_level is exact, 0..FIFO_DEPTH.
- cts is registered: cts = (rx_level < FIFO_DEPTH - CTS_MARGIN), updated one cycle after a level change.
- Reset asserted mid-frame discards the partial word immediately. After release, the block waits for a fresh falling edge; a line already low after release is ignored until it returns high.

Test Plan:
- 0x62, 8N1, 104 cycles/bit, rx_data_ready = 0 -> after the stop mid-sample: rx_data_valid = 1, rx_data = 0x62, both error flags 0, rx_level = 1. Pulse rx_data_ready -> valid = 0, level = 0.
- PARITY=2, 0x62 sent with parity bit 1 -> parity_error = 0. Same frame with parity bit 0 -> parity_error = 1, rx_data = 0x62.
- 20-cycle low glitch on idle rx -> no push, level stays 0. Stop bit driven 0 on 0xA5 -> rx_data = 0xA5, frame_error = 1. Line held low 3000 cycles -> exactly one word, 0x00 with frame_error = 1.
- 17 frames 0x00..0x10 sent without popping (DEPTH 16, margin 2) -> cts drops when level reaches 14; level ends at 16; overrun = 1; head = 0x00; the 16th popped word = 0x0F. error_clear -> overrun = 0.
- Frame arriving while the FIFO is full and rx_data_ready is held high at the push cycle -> no overrun, level stays 16.
- Reset asserted during data bit 4, released 10 cycles later while rx = 1; then a clean 0x3C frame -> only 0x3C received, level = 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with majority-voted mid-bit sampling, parity and
// stop-bit checking, feeding a first-word-fall-through FIFO with cts and overrun.
module uart_rx_fifo #(
  parameter int CLOCK_HZ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_MARGIN = 2
) (
  input  logic                          clock_12mhz,
  input  logic                          reset,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_error,
  output logic                          rx_parity_error,
  output logic                          rx_data_valid,
  input  logic                          rx_data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          cts,
  output logic                          overrun,
  input  logic                          error_clear
);
  // state    | meaning
  // S_IDLE   | line idle, waiting for a falling edge
  // S_START  | start bit, abort if mid-sample is high
  // S_DATA   | shifting data bits LSB first
  // S_PARITY | checking the parity bit
  // S_STOP   | checking stop bits, push at last stop mid-sample
  // S_BREAK  | line still low after push, wait for it to rise
  localparam int BIT_CYCLES = (CLOCK_HZ + BAUD / 2) / BAUD;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int TW         = $clog2(BIT_CYCLES);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int LW         = AW + 1;
  localparam int WW         = DATA_BITS + 2;
  localparam logic [TW-1:0] TMR_LOAD = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] SMP_A    = TW'(BIT_CYCLES - HALF);
  localparam logic [TW-1:0] SMP_B    = TW'(BIT_CYCLES - HALF - 1);
  localparam logic [TW-1:0] SMP_C    = TW'(BIT_CYCLES - HALF - 2);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          HAS_PAR  = (PARITY != 0);
  localparam logic          PAR_ODD  = (PARITY == 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] CTS_LVL  = LW'(FIFO_DEPTH - CTS_MARGIN);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               state, state_nxt;
  logic [1:0]           sync, sync_vld;
  logic                 rxs, rxs_prev, fall;
  logic [TW-1:0]        tmr, tmr_nxt;
  logic [3:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 v0, v1, v0_nxt, v1_nxt, mid, bit_val;
  logic                 par_err, par_err_nxt, frm_err, frm_err_nxt;
  logic                 push;
  logic [WW-1:0]        push_word;

  // rxs_prev only follows rxs once the synchroniser holds real line samples,
  // so a line that is already low when reset is released is not a start bit.
  assign rxs  = sync[1];
  assign fall = rxs_prev & ~rxs;

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      sync     <= 2'b11;
      sync_vld <= 2'b00;
      rxs_prev <= 1'b0;
    end else begin
      sync     <= {sync[0], rx};
      sync_vld <= {sync_vld[0], 1'b1};
      rxs_prev <= sync_vld[1] & rxs;
    end
  end

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tmr     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      v0      <= 1'b0;
      v1      <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      v0      <= v0_nxt;
      v1      <= v1_nxt;
      par_err <= par_err_nxt;
      frm_err <= frm_err_nxt;
    end
  end

  assign mid     = (tmr == SMP_C);
  assign bit_val = (v0 & v1) | (v0 & rxs) | (v1 & rxs);

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = (tmr == '0) ? TMR_LOAD : tmr - TW'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    v0_nxt      = (tmr == SMP_A) ? rxs : v0;
    v1_nxt      = (tmr == SMP_B) ? rxs : v1;
    par_err_nxt = par_err;
    frm_err_nxt = frm_err;
    push        = 1'b0;
    push_word   = {frm_err | ~bit_val, HAS_PAR & par_err, shreg};
    case (state)
      S_IDLE: begin
        tmr_nxt = TMR_LOAD;
        if (fall) state_nxt = S_START;
      end
      S_START: begin
        if (mid && bit_val) begin
          state_nxt = S_IDLE;
        end else if (tmr == '0) begin
          state_nxt   = S_DATA;
          bit_idx_nxt = '0;
          par_err_nxt = 1'b0;
          frm_err_nxt = 1'b0;
        end
      end
      S_DATA: begin
        if (mid) shreg_nxt = {bit_val, shreg[DATA_BITS-1:1]};
        if (tmr == '0) begin
          if (bit_idx == LAST_DATA) begin
            state_nxt   = HAS_PAR ? S_PARITY : S_STOP;
            bit_idx_nxt = '0;
          end else begin
            bit_idx_nxt = bit_idx + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (mid) par_err_nxt = ((^shreg) ^ bit_val) != PAR_ODD;
        if (tmr == '0) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (mid) begin
          if (!bit_val) frm_err_nxt = 1'b1;
          if (bit_idx == LAST_STOP) begin
            push      = 1'b1;
            state_nxt = rxs ? S_IDLE : S_BREAK;
          end
        end
        if (tmr == '0) bit_idx_nxt = bit_idx + 4'd1;
      end
      S_BREAK: begin
        tmr_nxt = TMR_LOAD;
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_show;
  logic          empty, full, pop, wr_en, drop;
  logic [WW-1:0] head;

  assign empty = (rx_level == '0);
  assign full  = (rx_level == FULL_LVL);
  assign pop   = ~empty & rx_data_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_level <= '0;
      cts      <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      rx_level <= rx_level + LW'(1);
      else if (pop && !wr_en) rx_level <= rx_level - LW'(1);
      cts <= (rx_level < CTS_LVL);
      if (drop)             overrun <= 1'b1;
      else if (error_clear) overrun <= 1'b0;
    end
  end

  // While empty, the slot behind rd_ptr still holds the last word popped.
  assign rd_show         = empty ? rd_ptr - AW'(1) : rd_ptr;
  assign head            = mem[rd_show];
  assign rx_data         = head[DATA_BITS-1:0];
  assign rx_parity_error = ~empty & head[DATA_BITS];
  assign rx_frame_error  = ~empty & head[DATA_BITS+1];
  assign rx_data_valid   = ~empty;
endmodule
